// File: rtl/dsp_mac_sequencer_if.sv
// Handshake and DSP48A1 slice signals for the MAC sequencer.
// The design side uses the slave modport; the driving environment uses master.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;

    logic             op_valid;
    logic             op_ready;
    logic [17:0]      op_a;
    logic [17:0]      op_b;

    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;

    logic [17:0]      DSP_A;
    logic [17:0]      DSP_B;
    logic [7:0]       DSP_OPMODE;
    logic             DSP_CEA;
    logic             DSP_CEB;
    logic             DSP_CEM;
    logic             DSP_CEP;
    logic [47:0]      DSP_P;

    logic             busy;

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready, DSP_P,
        output cmd_ready, op_ready, res_valid, res_data,
               DSP_A, DSP_B, DSP_OPMODE, DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, busy
    );

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready, DSP_P,
        input  cmd_ready, op_ready, res_valid, res_data,
               DSP_A, DSP_B, DSP_OPMODE, DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, busy
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer feeding a DSP48A1 slice (A1/B1, M and P registers enabled).
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | accepting operand pairs until remaining reaches 0
// DRAIN | waiting for the issue line to empty, then capturing P
// DONE  | result held on res_data until res_ready
module dsp_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              RSTN,
    dsp_mac_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic             r_first;
    logic             r_v0, r_v1, r_v2;
    logic [7:0]       r_opm0, r_opm1, r_opm2;
    logic [17:0]      r_dsp_a, r_dsp_b;
    logic [47:0]      r_res_data;

    logic w_cmd_fire;
    logic w_op_fire;
    logic w_op_ready;
    logic w_line_empty;

    assign w_op_ready   = (r_state == S_RUN) && (r_remaining != '0);
    assign w_cmd_fire   = bus.cmd_valid && (r_state == S_IDLE);
    assign w_op_fire    = bus.op_valid && w_op_ready;
    assign w_line_empty = !r_v0 && !r_v1 && !r_v2;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_opm0      <= 8'h00;
            r_opm1      <= 8'h00;
            r_opm2      <= 8'h00;
            r_dsp_a     <= 18'd0;
            r_dsp_b     <= 18'd0;
            r_res_data  <= 48'd0;
        end else begin
            r_v0   <= 1'b0;
            r_v1   <= r_v0;
            r_v2   <= r_v1;
            r_opm1 <= r_opm0;
            r_opm2 <= r_opm1;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_remaining <= bus.cmd_len;
                        r_first     <= 1'b1;
                        if (bus.cmd_len != '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_res_data <= 48'd0;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_op_fire) begin
                        r_dsp_a     <= bus.op_a;
                        r_dsp_b     <= bus.op_b;
                        r_v0        <= 1'b1;
                        // First pair ignores the stale P register (Z=0).
                        r_opm0      <= r_first ? OPM_FIRST : OPM_ACC;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_first     <= 1'b0;
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_line_empty) begin
                        r_res_data <= bus.DSP_P;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.op_ready   = w_op_ready;
    assign bus.res_valid  = (r_state == S_DONE);
    assign bus.res_data   = r_res_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.DSP_A      = r_dsp_a;
    assign bus.DSP_B      = r_dsp_b;
    assign bus.DSP_CEA    = r_v0;
    assign bus.DSP_CEB    = r_v0;
    assign bus.DSP_CEM    = r_v1;
    assign bus.DSP_CEP    = r_v2;
    assign bus.DSP_OPMODE = r_v2 ? r_opm2 : 8'h00;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1, M, P registers; Z selects 0 or P, X selects M).
module tb_dsp_mac_sequencer;
    logic clk = 1'b0;
    logic RSTN;
    always #5 clk = ~clk;

    dsp_mac_sequencer_if #(.LEN_W(8)) bus();
    dsp_mac_sequencer #(.LEN_W(8)) dut (.clk(clk), .RSTN(RSTN), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Slice model; P is deliberately never cleared, like the real slice.
    logic [17:0] m_a1 = 18'd0;
    logic [17:0] m_b1 = 18'd0;
    logic [35:0] m_m  = 36'd0;
    logic [47:0] m_p  = 48'h0000_1234_5678;
    assign bus.DSP_P = m_p;

    always @(posedge clk) begin
        if (bus.DSP_CEA) m_a1 <= bus.DSP_A;
        if (bus.DSP_CEB) m_b1 <= bus.DSP_B;
        if (bus.DSP_CEM) m_m  <= m_a1 * m_b1;
        if (bus.DSP_CEP)
            m_p <= ((bus.DSP_OPMODE[3:2] == 2'b10) ? m_p : 48'd0) +
                   ((bus.DSP_OPMODE[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0);
    end

    int         cea_cnt = 0;
    int         cep_cnt = 0;
    int         adj_cnt = 0;
    logic       prev_cea = 1'b0;
    logic [7:0] opm_log [64];

    always @(posedge clk) begin
        if (bus.DSP_CEA) begin
            cea_cnt++;
            if (prev_cea) adj_cnt++;
        end
        prev_cea = bus.DSP_CEA;
        if (bus.DSP_CEP) begin
            if (cep_cnt < 64) opm_log[cep_cnt] = bus.DSP_OPMODE;
            cep_cnt++;
        end
    end

    task automatic send_cmd(input logic [7:0] len);
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [17:0] a, input logic [17:0] b, input int gap, output bit ok);
        ok = 1'b0;
        bus.op_a = a;
        bus.op_b = b;
        bus.op_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (bus.op_ready) begin
                    @(posedge clk);
                    #1 ok = 1'b1;
                end
            end
        end
        bus.op_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_res(output int cyc);
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (cyc < 0) begin
                @(negedge clk);
                if (bus.res_valid) cyc = i;
            end
        end
    endtask

    task automatic res_accept();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.op_ready !== 1'b0 || bus.res_data !== 48'd0 || bus.DSP_OPMODE !== 8'h00 ||
            bus.DSP_CEA !== 1'b0 || bus.DSP_CEB !== 1'b0 || bus.DSP_CEM !== 1'b0 ||
            bus.DSP_CEP !== 1'b0 || bus.DSP_A !== 18'd0 || bus.DSP_B !== 18'd0) begin
            bad++;
            $display("FAIL %s: cmd_ready=%b busy=%b res_valid=%b op_ready=%b res_data=%0d opm=%h ce=%b%b%b%b a=%0d b=%0d, required cmd_ready=1 and all others 0",
                     tag, bus.cmd_ready, bus.busy, bus.res_valid, bus.op_ready, bus.res_data, bus.DSP_OPMODE,
                     bus.DSP_CEA, bus.DSP_CEB, bus.DSP_CEM, bus.DSP_CEP, bus.DSP_A, bus.DSP_B);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        repeat (2) @(posedge clk);
        #2 check_reset_outputs("reset_state");
        @(negedge clk) RSTN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int cea0, cep0, cyc;
        bit ok;
        cea0 = cea_cnt; cep0 = cep_cnt;
        send_cmd(8'd1);
        total++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL single_busy: busy=%b cmd_ready=%b, required 1/0", bus.busy, bus.cmd_ready);
        end
        send_op(18'd3, 18'd5, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_op: op handshake timed out"); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (m_p !== 48'd15 || bus.res_valid !== 1'b0) begin
            bad++; $display("FAIL single_e4: P=%0d res_valid=%b, required 15/0", m_p, bus.res_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 48'd15) begin
            bad++; $display("FAIL single_e5: res_valid=%b res_data=%0d, required 1/15", bus.res_valid, bus.res_data);
        end
        total++;
        if (cea_cnt - cea0 != 1 || cep_cnt - cep0 != 1 || opm_log[cep0] !== 8'h01) begin
            bad++; $display("FAIL single_ce: cea=%0d cep=%0d opm=%h, required 1/1/01", cea_cnt - cea0, cep_cnt - cep0, opm_log[cep0]);
        end
        res_accept();
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            bad++; $display("FAIL single_idle: cmd_ready=%b res_valid=%b, required 1/0", bus.cmd_ready, bus.res_valid);
        end
        cyc = 0;
    endtask

    task automatic test_back_to_back();
        int cea0, cep0, adj0, cyc;
        bit ok, all_ok;
        cea0 = cea_cnt; cep0 = cep_cnt; adj0 = adj_cnt;
        all_ok = 1'b1;
        send_cmd(8'd4);
        send_op(18'd1, 18'd2, 0, ok); all_ok &= ok;
        send_op(18'd3, 18'd4, 0, ok); all_ok &= ok;
        send_op(18'd5, 18'd6, 0, ok); all_ok &= ok;
        send_op(18'd7, 18'd8, 0, ok); all_ok &= ok;
        wait_res(cyc);
        total++;
        if (!all_ok || cyc < 0) begin bad++; $display("FAIL b2b_timeout: ops_ok=%b wait=%0d", all_ok, cyc); end
        total++;
        if (bus.res_data !== 48'd100) begin
            bad++; $display("FAIL b2b_data: res_data=%0d, required 100", bus.res_data);
        end
        total++;
        if (opm_log[cep0] !== 8'h01 || opm_log[cep0+1] !== 8'h09 ||
            opm_log[cep0+2] !== 8'h09 || opm_log[cep0+3] !== 8'h09) begin
            bad++; $display("FAIL b2b_opmode: %h %h %h %h, required 01 09 09 09",
                            opm_log[cep0], opm_log[cep0+1], opm_log[cep0+2], opm_log[cep0+3]);
        end
        total++;
        if (cea_cnt - cea0 != 4 || cep_cnt - cep0 != 4 || adj_cnt - adj0 != 3) begin
            bad++; $display("FAIL b2b_ce: cea=%0d cep=%0d adjacent=%0d, required 4/4/3",
                            cea_cnt - cea0, cep_cnt - cep0, adj_cnt - adj0);
        end
        res_accept();
    endtask

    task automatic test_gaps();
        int cea0, cep0, adj0, cyc;
        bit ok, all_ok;
        cea0 = cea_cnt; cep0 = cep_cnt; adj0 = adj_cnt;
        all_ok = 1'b1;
        send_cmd(8'd3);
        send_op(18'd2, 18'd3, 2, ok); all_ok &= ok;
        send_op(18'd4, 18'd5, 2, ok); all_ok &= ok;
        send_op(18'd6, 18'd7, 0, ok); all_ok &= ok;
        wait_res(cyc);
        total++;
        if (!all_ok || cyc < 0) begin bad++; $display("FAIL gaps_timeout: ops_ok=%b wait=%0d", all_ok, cyc); end
        total++;
        if (bus.res_data !== 48'd68) begin
            bad++; $display("FAIL gaps_data: res_data=%0d, required 68", bus.res_data);
        end
        total++;
        if (cea_cnt - cea0 != 3 || cep_cnt - cep0 != 3 || adj_cnt - adj0 != 0) begin
            bad++; $display("FAIL gaps_ce: cea=%0d cep=%0d adjacent=%0d, required 3/3/0",
                            cea_cnt - cea0, cep_cnt - cep0, adj_cnt - adj0);
        end
        res_accept();
    endtask

    task automatic test_zero();
        int cea0, cep0;
        cea0 = cea_cnt; cep0 = cep_cnt;
        send_cmd(8'd0);
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 48'd0) begin
            bad++; $display("FAIL zero_res: res_valid=%b res_data=%0d, required 1/0", bus.res_valid, bus.res_data);
        end
        res_accept();
        total++;
        if (cea_cnt - cea0 != 0 || cep_cnt - cep0 != 0) begin
            bad++; $display("FAIL zero_ce: cea=%0d cep=%0d, required 0/0", cea_cnt - cea0, cep_cnt - cep0);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok, all_ok;
        all_ok = 1'b1;
        send_cmd(8'd2);
        send_op(18'd10, 18'd20, 0, ok); all_ok &= ok;
        send_op(18'd30, 18'd40, 0, ok); all_ok &= ok;
        wait_res(cyc);
        total++;
        if (!all_ok || cyc < 0) begin bad++; $display("FAIL bp_timeout: ops_ok=%b wait=%0d", all_ok, cyc); end
        // A command offered while the result is pending must be ignored.
        bus.cmd_len   = 8'd1;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 48'd1400 || bus.cmd_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: res_valid=%b res_data=%0d cmd_ready=%b, required 1/1400/0",
                                i, bus.res_valid, bus.res_data, bus.cmd_ready);
            end
        end
        #4 bus.cmd_valid = 1'b0;
        res_accept();
        send_cmd(8'd1);
        send_op(18'd2, 18'd2, 0, ok);
        wait_res(cyc);
        total++;
        if (!ok || cyc < 0 || bus.res_data !== 48'd4) begin
            bad++; $display("FAIL bp_next: ok=%b wait=%0d res_data=%0d, required res_data 4", ok, cyc, bus.res_data);
        end
        res_accept();
    endtask

    task automatic test_reset_mid();
        int cyc, seen;
        bit ok, all_ok;
        all_ok = 1'b1;
        send_cmd(8'd2);
        send_op(18'd3, 18'd3, 0, ok); all_ok &= ok;
        send_op(18'd4, 18'd4, 0, ok); all_ok &= ok;
        total++;
        if (!all_ok || bus.busy !== 1'b1 || bus.op_ready !== 1'b0) begin
            bad++; $display("FAIL mid_drain: ops_ok=%b busy=%b op_ready=%b, required 1/1/0", all_ok, bus.busy, bus.op_ready);
        end
        #2 RSTN = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk) RSTN = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_no_res: res_valid cycles=%0d, required 0", seen); end
        send_cmd(8'd1);
        send_op(18'd9, 18'd9, 0, ok);
        wait_res(cyc);
        total++;
        if (!ok || cyc < 0 || bus.res_data !== 48'd81) begin
            bad++; $display("FAIL mid_next: ok=%b wait=%0d res_data=%0d, required res_data 81", ok, cyc, bus.res_data);
        end
        res_accept();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 8'd0;
        bus.op_valid  = 1'b0;
        bus.op_a      = 18'd0;
        bus.op_b      = 18'd0;
        bus.res_ready = 1'b0;
        RSTN          = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
